// File: rtl/chip8_rand_request_unit.sv
// CHIP-8 CXNN random-request unit: harvests generator bytes into a small FIFO and serves masked bytes.
// Define CHIP8_RAND_HEALTH_CHECK_EN to add the stuck/zero generator health checker driving rng_fault.
module chip8_rand_request_unit #(
    parameter int FIFO_DEPTH  = 4,
    parameter int STUCK_LIMIT = 8
) (
    input  logic                        cpu_clk,
    input  logic                        reset_n,
    input  logic [15:0]                 rand_in,
    input  logic                        req_valid,
    input  logic [7:0]                  req_nn,
    input  logic [3:0]                  req_x,
    output logic                        req_ready,
    output logic                        rsp_valid,
    output logic [7:0]                  rsp_data,
    output logic [3:0]                  rsp_x,
    output logic                        rsp_err,
    output logic                        rng_fault,
    output logic [1:0]                  dbg_state,
    output logic [$clog2(FIFO_DEPTH):0] dbg_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and rsp_valid pulses for exactly one cycle per request.
    state_t          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      nn_q, nn_d;
    logic [3:0]      x_q, x_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic [3:0]      rsp_x_q, rsp_x_d;
    logic            rsp_err_q, rsp_err_d;
    logic            rng_fault_q;
    logic [7:0]      harvest;
    logic [7:0]      head;
    logic            push, pop, empty;

    assign harvest = rand_in[15:8] ^ rand_in[7:0];
    assign head    = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    // A full FIFO refuses the harvest even when a pop happens in the same cycle.
    assign push    = (count_q != CW'(FIFO_DEPTH)) && !rng_fault_q;

    always_comb begin
        state_d     = state_q;
        nn_d        = nn_q;
        x_d         = x_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_x_d     = rsp_x_q;
        rsp_err_d   = rsp_err_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    nn_d = req_nn;
                    x_d  = req_x;
                    if (!empty) begin
                        pop         = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = head & req_nn;
                        rsp_x_d     = req_x;
                        rsp_err_d   = 1'b0;
                        state_d     = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!empty) begin
                    pop         = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = head & nn_q;
                    rsp_x_d     = x_q;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else if (rng_fault_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 8'h00;
                    rsp_x_d     = x_q;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = harvest;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            nn_q        <= '0;
            x_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_x_q     <= '0;
            rsp_err_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            nn_q        <= nn_d;
            x_q         <= x_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_x_q     <= rsp_x_d;
            rsp_err_q   <= rsp_err_d;
            mem_q       <= mem_d;
        end
    end

`ifdef CHIP8_RAND_HEALTH_CHECK_EN
    localparam int SW = $clog2(STUCK_LIMIT + 1);

    logic [15:0]   prev_q, prev_d;
    logic [SW-1:0] stuck_q, stuck_d;
    logic          rng_fault_d;

    // Stuck counter saturates once the limit is reached; the fault is sticky until reset.
    always_comb begin
        prev_d = rand_in;
        if (rand_in == prev_q) begin
            stuck_d = (stuck_q == SW'(STUCK_LIMIT - 1)) ? stuck_q : stuck_q + SW'(1);
        end else begin
            stuck_d = '0;
        end
        rng_fault_d = rng_fault_q || (stuck_d == SW'(STUCK_LIMIT - 1)) || (rand_in == 16'h0000);
    end

    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q      <= '0;
            stuck_q     <= '0;
            rng_fault_q <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            stuck_q     <= stuck_d;
            rng_fault_q <= rng_fault_d;
        end
    end
`else
    assign rng_fault_q = 1'b0;
`endif

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_err   = rsp_err_q;
    assign rng_fault = rng_fault_q;
    assign dbg_state = state_q;
    assign dbg_count = count_q;

endmodule

// File: tb/tb_chip8_rand_request_unit.sv
// Bench for chip8_rand_request_unit: directed scenarios plus random traffic checked against a queue-based model.
// Build with CHIP8_RAND_HEALTH_CHECK_EN defined to also exercise the generator fault path.
module tb_chip8_rand_request_unit;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        cpu_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] rand_in = 16'h0;
    logic        req_valid = 1'b0;
    logic [7:0]  req_nn = 8'h0;
    logic [3:0]  req_x = 4'h0;
    logic        req_ready, rsp_valid, rsp_err, rng_fault;
    logic [7:0]  rsp_data;
    logic [3:0]  rsp_x;
    logic [1:0]  dbg_state;
    logic [$clog2(DEPTH):0] dbg_count;

    chip8_rand_request_unit #(.FIFO_DEPTH(DEPTH), .STUCK_LIMIT(LIMIT)) dut (
        .cpu_clk(cpu_clk), .reset_n(reset_n), .rand_in(rand_in),
        .req_valid(req_valid), .req_nn(req_nn), .req_x(req_x),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_x(rsp_x), .rsp_err(rsp_err), .rng_fault(rng_fault),
        .dbg_state(dbg_state), .dbg_count(dbg_count)
    );

    // ---------------- clock ----------------
    always #5 cpu_clk = ~cpu_clk;

    // ---------------- scoreboard / model state ----------------
    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  m_fifo[$];
    logic [12:0] exp_q[$];
    logic [7:0]  harvest_log[$];
    bit          m_wait, m_valid, m_fault, m_err;
    logic [7:0]  m_nn, m_data;
    logic [3:0]  m_x, m_rx;
    logic [15:0] m_prev;
    int          m_stuck;
    bit          hold_en = 1'b0;
    logic [15:0] hold_val = 16'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        harvest_log.delete();
        m_wait = 0; m_valid = 0; m_fault = 0; m_err = 0;
        m_nn = 0; m_x = 0; m_data = 0; m_rx = 0;
        m_prev = 0; m_stuck = 0;
    endtask

    // One clock of the reference behaviour, using the inputs present at the rising edge.
    task automatic model_step();
        logic [7:0] h;
        int         size0;
        bit         accept, fault0, serve;
        h      = rand_in[15:8] ^ rand_in[7:0];
        size0  = m_fifo.size();
        fault0 = m_fault;
        accept = req_valid && !m_wait && !m_valid;
        serve  = 0;
        m_valid = 0;
        if (accept) begin
            m_nn = req_nn;
            m_x  = req_x;
        end
        if (accept || m_wait) begin
            if (size0 > 0) begin
                m_data = m_fifo.pop_front() & m_nn;
                m_err  = 0;
                serve  = 1;
            end else if (m_wait && fault0) begin
                m_data = 8'h00;
                m_err  = 1;
                serve  = 1;
            end else begin
                m_wait = 1;
            end
        end
        if (serve) begin
            m_wait  = 0;
            m_valid = 1;
            m_rx    = m_x;
            exp_q.push_back({m_err, m_rx, m_data});
        end
        if (size0 < DEPTH && !fault0) begin
            m_fifo.push_back(h);
            harvest_log.push_back(h);
        end
`ifdef CHIP8_RAND_HEALTH_CHECK_EN
        if (rand_in == m_prev) m_stuck++;
        else m_stuck = 0;
        if (m_stuck >= LIMIT - 1 || rand_in == 16'h0000) m_fault = 1;
        m_prev = rand_in;
`endif
    endtask

    // Monitor: advance the model on each edge, compare DUT outputs 1ns later.
    always @(posedge cpu_clk) begin
        if (reset_n) begin
            model_step();
            #1;
            check("rsp_valid", rsp_valid, m_valid);
            check("req_ready", req_ready, !m_wait && !m_valid);
            check("rng_fault", rng_fault, m_fault);
            check("rsp_hold", {rsp_err, rsp_x, rsp_data}, {m_err, m_rx, m_data});
            if (rsp_valid) begin
                check("rsp_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("rsp_fields", {rsp_err, rsp_x, rsp_data}, exp_q.pop_front());
            end
        end
    end

    // Generator stand-in: new word every cycle unless a test holds it.
    always @(negedge cpu_clk) rand_in = hold_en ? hold_val : 16'($urandom);

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge cpu_clk);
        reset_n = 0;
        req_valid = 0;
        model_reset();
        repeat (2) @(negedge cpu_clk);
        check("rst_valid", rsp_valid, 0);
        check("rst_ready", req_ready, 1);
        check("rst_data", rsp_data, 8'h00);
        check("rst_x", rsp_x, 4'h0);
        check("rst_err", rsp_err, 0);
        check("rst_fault", rng_fault, 0);
        check("rst_count", dbg_count, 0);
        reset_n = 1;
    endtask

    task automatic send_req(input logic [7:0] nn, input logic [3:0] x);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge cpu_clk);
            n++;
        end
        check("req_ready_wait", req_ready, 1);
        req_valid = 1; req_nn = nn; req_x = x;
        @(negedge cpu_clk);
        req_valid = 0;
    endtask

    task automatic wait_rsp(output logic [7:0] d, output logic e);
        int n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge cpu_clk);
            n++;
        end
        check("rsp_arrives", rsp_valid, 1);
        d = rsp_data;
        e = rsp_err;
        @(negedge cpu_clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] d;
        logic       e;

        // Single held word F5D2 -> harvest 0x27, masked with 0x0F -> 0x07 one cycle after accept.
        do_reset();
        hold_en = 1; hold_val = 16'hF5D2; rand_in = 16'hF5D2;
        @(negedge cpu_clk);
        hold_en = 0;
        req_valid = 1; req_nn = 8'h0F; req_x = 4'h3;
        @(negedge cpu_clk);
        req_valid = 0;
        check("t34_valid", rsp_valid, 1);
        check("t34_data", rsp_data, 8'h07);
        check("t34_x", rsp_x, 4'h3);
        check("t34_err", rsp_err, 0);
        @(negedge cpu_clk);
        check("t34_one_cycle", rsp_valid, 0);

        // Request on the first cycle after reset: empty FIFO, response two cycles later.
        do_reset();
        req_valid = 1; req_nn = 8'hFF; req_x = 4'h5;
        @(negedge cpu_clk);
        req_valid = 0;
        check("t35_ready_wait", req_ready, 0);
        check("t35_no_early_rsp", rsp_valid, 0);
        @(negedge cpu_clk);
        check("t35_rsp_two_cycles", rsp_valid, 1);
        check("t35_ready_resp", req_ready, 0);
        check("t35_data", rsp_data, harvest_log[0]);
        @(negedge cpu_clk);

        // Idle fill saturates at DEPTH; back-to-back requests return the oldest bytes in order.
        do_reset();
        repeat (10) @(negedge cpu_clk);
        check("t36_count_sat", dbg_count, DEPTH);
        for (int i = 0; i < 4; i++) begin
            send_req(8'hFF, 4'(i));
            wait_rsp(d, e);
            check("t36_order", d, harvest_log[i]);
        end

        // Mask boundaries.
        send_req(8'h00, 4'h1);
        wait_rsp(d, e);
        check("t39_nn00", d, 8'h00);

`ifdef CHIP8_RAND_HEALTH_CHECK_EN
        // Stuck generator: fault after 8 identical samples, then error response once drained.
        do_reset();
        hold_en = 1; hold_val = 16'h1234; rand_in = 16'h1234;
        repeat (7) @(negedge cpu_clk);
        check("t37_no_fault_yet", rng_fault, 0);
        @(negedge cpu_clk);
        check("t37_fault", rng_fault, 1);
        for (int i = 0; i < DEPTH; i++) begin
            send_req(8'hFF, 4'h2);
            wait_rsp(d, e);
            check("t37_drain_data", d, 8'h26);
            check("t37_drain_err", e, 0);
        end
        send_req(8'hFF, 4'h2);
        wait_rsp(d, e);
        check("t37_err_data", d, 8'h00);
        check("t37_err_flag", e, 1);
        hold_en = 0;
`endif

        // Random traffic with periodic resets to revisit the empty-FIFO path.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                req_valid = ($urandom_range(0, 3) == 0);
                req_nn = 8'($urandom);
                req_x = 4'($urandom);
                @(negedge cpu_clk);
            end
            req_valid = 0;
            repeat (3) @(negedge cpu_clk);
        end

        // Reset pulsed while waiting: request dropped, outputs back at reset values immediately.
        do_reset();
        req_valid = 1; req_nn = 8'hAA; req_x = 4'h9;
        @(negedge cpu_clk);
        req_valid = 0;
        check("t38_in_wait", req_ready, 0);
        reset_n = 0;
        model_reset();
        #1;
        check("t38_valid", rsp_valid, 0);
        check("t38_ready", req_ready, 1);
        check("t38_state_idle", dbg_state, 2'd0);
        check("t38_data", rsp_data, 8'h00);
        check("t38_x", rsp_x, 4'h0);
        check("t38_err", rsp_err, 0);
        check("t38_count", dbg_count, 0);
        @(negedge cpu_clk);
        reset_n = 1;
        @(negedge cpu_clk);
        check("t38_ready_after", req_ready, 1);
        check("t38_no_rsp", rsp_valid, 0);
        repeat (4) @(negedge cpu_clk);

        check("exp_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/chip8_rand_request_unit.md
CHIP8_RAND_REQUEST_UNIT -- requirements
Module: chip8_rand_request_unit

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning harvested random byte buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter STUCK_LIMIT, default 8, meaning consecutive identical rand_in samples that declare a fault.
REQ-003 SHALL have port cpu_clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rand_in, input, 16 bits: free-running pseudo-random word from the generator, which changes each cpu_clk.
REQ-006 SHALL have port req_valid, input, 1 bit: CXNN random request.
REQ-007 SHALL have port req_nn, input, 8 bits: mask NN.
REQ-008 SHALL have port req_x, input, 4 bits: destination register index.
REQ-009 SHALL have port req_ready, output, 1 bit: high only in IDLE.
REQ-010 SHALL have port rsp_valid, output, 1 bit: one-cycle result strobe.
REQ-011 SHALL have port rsp_data, output, 8 bits: masked random byte.
REQ-012 SHALL have port rsp_x, output, 4 bits: echoed req_x.
REQ-013 SHALL have port rsp_err, output, 1 bit: result produced under fault, with rsp_data forced to 0x00.
REQ-014 SHALL have port rng_fault, output, 1 bit: sticky generator health fault.

Function
REQ-015 SHALL form the harvest byte as rand_in[15:8] XOR rand_in[7:0].
REQ-016 SHALL push one harvest byte per cycle into the FIFO when the FIFO is not full and rng_fault=0.
REQ-017 SHALL, when full, drop the harvest byte and leave FIFO contents unchanged.
REQ-018 SHALL allow push and pop in the same cycle, with the count unchanged; pop SHALL return the oldest entry, never the byte being pushed.
REQ-019 SHALL wrap read and write pointers modulo FIFO_DEPTH, with the count ranging 0..FIFO_DEPTH.
REQ-020 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-021 SHALL accept a request when req_valid=1 and req_ready=1; on acceptance it SHALL capture req_nn and req_x.
REQ-022 SHALL, in IDLE on accept with count>0, pop, register rsp_data=byte AND req_nn, and go to RESP (rsp_valid on the next cycle: latency 1).
REQ-023 SHALL, in IDLE on accept with count=0, go to WAIT.
REQ-024 SHALL, in WAIT with count>0, pop, register rsp_data=byte AND captured nn, and go to RESP.
REQ-025 SHALL, in WAIT with count=0 and rng_fault=1, set rsp_data=0x00 and rsp_err=1, and go to RESP.
REQ-026 SHALL assert rsp_valid in RESP for exactly one cycle and then go to IDLE; rsp_data, rsp_x and rsp_err SHALL hold until the next response.
REQ-027 SHALL ignore req_valid outside IDLE, with no queueing.
REQ-028 SHALL serve requests from FIFO contents even while rng_fault=1, with rsp_err=0 for those responses.

Reset
REQ-029 SHALL, on reset_n=0, immediately set: state IDLE, FIFO count 0, pointers 0, rsp_valid=0, rsp_data=0x00, rsp_x=0x0, rsp_err=0, rng_fault=0, and stuck counter 0.
REQ-030 SHALL, on reset asserted mid-request, discard the request with no rsp_valid; the first harvest SHALL occur on the first rising edge after reset_n rises.

Configuration
REQ-031 SHALL, with macro CHIP8_RAND_HEALTH_CHECK_EN defined, register the previous rand_in and increment the stuck counter when rand_in equals it, clearing the counter otherwise.
REQ-032 SHALL, with CHIP8_RAND_HEALTH_CHECK_EN defined, set rng_fault when the counter reaches STUCK_LIMIT-1 or when rand_in=0x0000; rng_fault SHALL clear only on reset.
REQ-033 SHALL, without CHIP8_RAND_HEALTH_CHECK_EN, omit the checker logic and tie rng_fault to 0, so that REQ-025 is unreachable.

Verification
REQ-034 SHALL cover: rand_in=0xF5D2 held one cycle after reset, then a request with nn=0x0F and x=0x3 -> rsp_valid one cycle after accept, with rsp_data=0x07, rsp_x=0x3 and rsp_err=0.
REQ-035 SHALL cover: a request on the first cycle after reset (FIFO empty) -> WAIT, with the response two cycles after accept and req_ready=0 throughout.
REQ-036 SHALL cover: 10 cycles with no requests, FIFO_DEPTH=4 -> count saturates at 4, and four back-to-back requests return the first four harvested bytes in order.
REQ-037 SHALL cover, with the macro defined: rand_in held at 0x1234 for 8 cycles -> rng_fault=1; after draining the FIFO, the next request returns rsp_data=0x00 with rsp_err=1.
REQ-038 SHALL cover: reset_n pulsed low while in WAIT -> no rsp_valid, all outputs at reset values, req_ready=1 on the next cycle.
REQ-039 SHALL cover: nn=0x00 -> rsp_data=0x00; nn=0xFF -> rsp_data equals the harvested byte exactly.
